reset_ctrl: RTL and testbench

// Board reset sequencer downstream of the watchdog. Consumes wdt_out[1:0],
// an external reset button and a CSR soft-reset request. Drives the board

---
 rtl/reset_ctrl_pkg.sv | 26 ++
 rtl/sync2.sv | 23 ++
 rtl/reset_ctrl.sv | 118 +++++++++++
 tb/tb_reset_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_ctrl_pkg.sv
// Shared definitions for the board reset sequencer: CSR offsets, cause bits, FSM states.
// The cause-bit indices match the bit layout of R_CAUSE.
package reset_ctrl_pkg;

  localparam logic [4:0] R_CAUSE = 5'd0;
  localparam logic [4:0] R_HOLD  = 5'd1;
  localparam logic [4:0] R_SOFT  = 5'd2;

  localparam int C_POR  = 0;
  localparam int C_EXT  = 1;
  localparam int C_SOFT = 2;
  localparam int C_WDT0 = 3;
  localparam int C_WDT1 = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // A hold of zero still gives one tick of reset.
  function automatic logic [7:0] hold_load(input logic [7:0] h);
    return (h == 8'd0) ? 8'd1 : h;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous pin inputs; INIT sets the value held through rst.
module sync2 #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_ctrl.sv
// Board reset sequencer: merges button, watchdog bites and CSR soft requests into
// sys_rst_n/core_rst with a programmable hold, fixed settle blanking and sticky cause.
module reset_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR    = 5'h0,
  parameter logic [7:0] DFL_HOLD     = 8'h10,
  parameter logic [7:0] SETTLE_TICKS = 8'h04,
  parameter logic [7:0] SOFT_VALUE   = 8'h5a
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic [1:0] wdt_in,
  input  logic       ext_rst_n,
  output logic       sys_rst_n,
  output logic       core_rst
);

  localparam logic [4:0] A_CAUSE = BASE_ADDR + R_CAUSE;
  localparam logic [4:0] A_HOLD  = BASE_ADDR + R_HOLD;
  localparam logic [4:0] A_SOFT  = BASE_ADDR + R_SOFT;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] hold;
  logic [4:0] cause, cause_set, cause_clr;
  logic [1:0] wdt_prev, wdt_edge;
  logic       ext_sync, ext_req, soft_req, req;

  sync2 #(.INIT(1'b1)) u_ext_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_rst_n),
    .q   (ext_sync)
  );

  // The bite may stay high through core_rst, so only rising edges count.
  assign wdt_edge = wdt_in & ~wdt_prev;
  assign ext_req  = ~ext_sync;
  assign soft_req = csr_we && (csr_a == A_SOFT) && (csr_di == SOFT_VALUE);
  assign req      = ext_req | (|wdt_edge) | soft_req;

  assign cause_set = {wdt_edge[1], wdt_edge[0], soft_req, ext_req, 1'b0};
  assign cause_clr = (csr_we && (csr_a == A_CAUSE)) ? csr_di[4:0] : 5'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ASSERT;
      cnt      <= DFL_HOLD;
      hold     <= DFL_HOLD;
      cause    <= 5'b00001;
      wdt_prev <= 2'b00;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wdt_prev <= wdt_in;
      cause    <= (cause & ~cause_clr) | cause_set;
      if (csr_we && (csr_a == A_HOLD))
        hold <= csr_di;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_n = ASSERT;
          cnt_n   = hold_load(hold);
        end
      end
      ASSERT: begin
        if (req) begin
          cnt_n = hold_load(hold);
        end else if (ce) begin
          if (cnt <= 8'd1) begin
            state_n = (SETTLE_TICKS == 8'd0) ? IDLE : SETTLE;
            cnt_n   = SETTLE_TICKS;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
      end
      SETTLE: begin
        if (req) begin
          state_n = ASSERT;
          cnt_n   = hold_load(hold);
        end else if (cnt == 8'd0) begin
          state_n = IDLE;
        end else if (ce) begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = ASSERT;
        cnt_n   = hold_load(hold);
      end
    endcase
  end

  assign sys_rst_n = (state != ASSERT);
  assign core_rst  = (state == ASSERT);

  always_comb begin
    csr_do = 8'd0;
    if (csr_a == A_CAUSE)
      csr_do = {3'd0, cause};
    else if (csr_a == A_HOLD)
      csr_do = hold;
  end

endmodule

// File: tb/tb_reset_ctrl.sv
// Directed bench for reset_ctrl: hold/settle timing in ce ticks, cause register,
// request sources, back-to-back retrigger and W1C/set collision.
module tb_reset_ctrl;
  import reset_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic [4:0] csr_a = 5'd0;
  logic [7:0] csr_di = 8'd0;
  logic       csr_we = 1'b0;
  logic [7:0] csr_do;
  logic [1:0] wdt_in = 2'b00;
  logic       ext_rst_n = 1'b1;
  logic       sys_rst_n;
  logic       core_rst;

  int         n_chk = 0;
  int         n_fail = 0;
  int         tick_cnt = 0;
  logic [1:0] div = 2'd0;

  reset_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .csr_a     (csr_a),
    .csr_di    (csr_di),
    .csr_we    (csr_we),
    .csr_do    (csr_do),
    .wdt_in    (wdt_in),
    .ext_rst_n (ext_rst_n),
    .sys_rst_n (sys_rst_n),
    .core_rst  (core_rst)
  );

  always #5 clk = ~clk;

  // ce high one clock in four; tick_cnt counts the posedges that see it.
  always @(negedge clk) begin
    ce  <= (div == 2'd3);
    div <= div + 2'd1;
  end

  always @(posedge clk) if (ce) tick_cnt <= tick_cnt + 1;

  task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0; csr_di = 8'd0;
  endtask

  task automatic csr_read(input logic [4:0] a, output logic [7:0] d);
    csr_a = a;
    #1;
    d = csr_do;
  endtask

  task automatic wait_high(output bit ok);
    int g = 0;
    while (sys_rst_n !== 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    ok = (sys_rst_n === 1'b1);
  endtask

  // Ticks seen from now until sys_rst_n releases.
  task automatic measure_low(output int ticks, output bit ok);
    int t0 = tick_cnt;
    wait_high(ok);
    ticks = tick_cnt - t0;
  endtask

  task automatic test_reset;
    logic [7:0] d; int t; bit ok; int t1; int g;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys: got %b expected 0", sys_rst_n); end
    n_chk++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core: got %b expected 1", core_rst); end
    csr_read(R_CAUSE, d);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL reset_cause: got %h expected 01", d); end
    csr_read(R_HOLD, d);
    n_chk++; if (d !== 8'h10) begin n_fail++; $display("FAIL reset_hold: got %h expected 10", d); end
    measure_low(t, ok);
    n_chk++; if (!ok || t != 16) begin n_fail++; $display("FAIL por_assert_ticks: got %0d (ok=%0d) expected 16", t, ok); end
    n_chk++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL por_core_release: got %b expected 0", core_rst); end
    n_chk++; if (dut.state !== SETTLE) begin n_fail++; $display("FAIL por_settle_entry: got %0d expected %0d", dut.state, SETTLE); end
    t1 = tick_cnt; g = 0;
    while (tick_cnt < t1 + 4 && g < 100) begin @(negedge clk); g++; end
    n_chk++; if (dut.state !== SETTLE) begin n_fail++; $display("FAIL settle_4th_tick: got %0d expected %0d", dut.state, SETTLE); end
    @(negedge clk);
    n_chk++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL settle_to_idle: got %0d expected %0d", dut.state, IDLE); end
    csr_read(R_CAUSE, d);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL idle_cause: got %h expected 01", d); end
  endtask

  task automatic test_soft;
    logic [7:0] d; int t; bit ok; int low;
    csr_write(R_CAUSE, 8'h01);
    csr_read(R_CAUSE, d);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL w1c_por: got %h expected 00", d); end
    csr_write(R_SOFT, 8'h5a);
    n_chk++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL soft_next_clk: got %b expected 0", sys_rst_n); end
    csr_read(R_CAUSE, d);
    n_chk++; if (d !== 8'h04) begin n_fail++; $display("FAIL soft_cause: got %h expected 04", d); end
    csr_read(R_SOFT, d);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL soft_reads_zero: got %h expected 00", d); end
    measure_low(t, ok);
    n_chk++; if (!ok || t != 16) begin n_fail++; $display("FAIL soft_assert_ticks: got %0d (ok=%0d) expected 16", t, ok); end
    repeat (30) @(negedge clk);
    csr_write(R_CAUSE, 8'h04);
    csr_write(R_SOFT, 8'h5b);
    low = 0;
    repeat (20) begin
      if (sys_rst_n !== 1'b1) low++;
      @(negedge clk);
    end
    n_chk++; if (low != 0) begin n_fail++; $display("FAIL soft_wrong_value: got %0d low clks expected 0", low); end
    csr_read(R_CAUSE, d);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL soft_wrong_cause: got %h expected 00", d); end
  endtask

  task automatic test_wdt;
    logic [7:0] d; int t; bit ok; int low;
    wdt_in = 2'b01;
    @(negedge clk);
    n_chk++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL wdt_assert: got %b expected 0", sys_rst_n); end
    measure_low(t, ok);
    n_chk++; if (!ok || t != 16) begin n_fail++; $display("FAIL wdt_assert_ticks: got %0d (ok=%0d) expected 16", t, ok); end
    low = 0;
    repeat (120) begin
      if (sys_rst_n !== 1'b1) low++;
      @(negedge clk);
    end
    n_chk++; if (low != 0) begin n_fail++; $display("FAIL wdt_retrigger: got %0d low clks expected 0", low); end
    csr_read(R_CAUSE, d);
    n_chk++; if (d !== 8'h08) begin n_fail++; $display("FAIL wdt_cause: got %h expected 08", d); end
    wdt_in = 2'b00;
    @(negedge clk);
    csr_write(R_CAUSE, 8'h1f);
  endtask

  task automatic test_ext;
    logic [7:0] d; int t; bit ok; logic [2:0] s; int ts; int g;
    ext_rst_n = 1'b0;
    @(negedge clk); s[0] = sys_rst_n;
    @(negedge clk); s[1] = sys_rst_n;
    @(negedge clk); s[2] = sys_rst_n;
    n_chk++; if (s !== 3'b011) begin n_fail++; $display("FAIL ext_latency: got %b expected 011", s); end
    ts = tick_cnt; g = 0;
    while (tick_cnt < ts + 40 && g < 400) begin @(negedge clk); g++; end
    n_chk++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL ext_level_hold: got %b expected 0", sys_rst_n); end
    ext_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL ext_sync_delay: got %b expected 0", sys_rst_n); end
    measure_low(t, ok);
    n_chk++; if (!ok || t != 16) begin n_fail++; $display("FAIL ext_release_ticks: got %0d (ok=%0d) expected 16", t, ok); end
    csr_read(R_CAUSE, d);
    n_chk++; if (d !== 8'h02) begin n_fail++; $display("FAIL ext_cause: got %h expected 02", d); end
    repeat (30) @(negedge clk);
    csr_write(R_CAUSE, 8'h1f);
  endtask

  task automatic test_back_to_back;
    logic [7:0] d; int t; bit ok; int t1; int g;
    csr_write(R_SOFT, 8'h5a);
    measure_low(t, ok);
    n_chk++; if (!ok || t != 16) begin n_fail++; $display("FAIL b2b_first_ticks: got %0d (ok=%0d) expected 16", t, ok); end
    t1 = tick_cnt; g = 0;
    while (tick_cnt < t1 + 2 && g < 100) begin @(negedge clk); g++; end
    wdt_in = 2'b10;
    @(negedge clk);
    n_chk++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL b2b_reassert: got %b expected 0", sys_rst_n); end
    measure_low(t, ok);
    n_chk++; if (!ok || t != 16) begin n_fail++; $display("FAIL b2b_full_reload: got %0d (ok=%0d) expected 16", t, ok); end
    csr_read(R_CAUSE, d);
    n_chk++; if (d !== 8'h14) begin n_fail++; $display("FAIL b2b_cause: got %h expected 14", d); end
    wdt_in = 2'b00;
    repeat (30) @(negedge clk);
    csr_write(R_CAUSE, 8'h1f);
    csr_write(R_HOLD, 8'h00);
    csr_read(R_HOLD, d);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL hold_write: got %h expected 00", d); end
    csr_write(R_SOFT, 8'h5a);
    n_chk++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL hold0_assert: got %b expected 0", sys_rst_n); end
    measure_low(t, ok);
    n_chk++; if (!ok || t != 1) begin n_fail++; $display("FAIL hold0_ticks: got %0d (ok=%0d) expected 1", t, ok); end
    repeat (30) @(negedge clk);
    csr_write(R_CAUSE, 8'h1f);
  endtask

  task automatic test_collision;
    logic [7:0] d; int t; bit ok;
    csr_write(R_HOLD, 8'h20);
    wdt_in = 2'b01;
    csr_write(R_CAUSE, 8'h08);
    csr_read(R_CAUSE, d);
    n_chk++; if (d !== 8'h08) begin n_fail++; $display("FAIL set_beats_w1c: got %h expected 08", d); end
    wdt_in = 2'b00;
    repeat (20) @(negedge clk);
    n_chk++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL long_hold_active: got %b expected 0", sys_rst_n); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL midrst_sys: got %b expected 0", sys_rst_n); end
    csr_read(R_CAUSE, d);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL midrst_cause: got %h expected 01", d); end
    csr_read(R_HOLD, d);
    n_chk++; if (d !== 8'h10) begin n_fail++; $display("FAIL midrst_hold: got %h expected 10", d); end
    measure_low(t, ok);
    n_chk++; if (!ok || t != 16) begin n_fail++; $display("FAIL midrst_ticks: got %0d (ok=%0d) expected 16", t, ok); end
  endtask

  initial begin
    test_reset();
    test_soft();
    test_wdt();
    test_ext();
    test_back_to_back();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
